// File: rtl/am_demod_pkg.sv
// am_demod_pkg: shared types and helpers for the AM envelope demodulator.
//   state_t  : MAC engine state (IDLE, MAC, DONE)
//   acc_bits : accumulator width that cannot overflow for a K-tap symmetric FIR
//   sat_s    : clamp a signed value to a signed 'width'-bit range
package am_demod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The pre-add is D+1 bits, the product adds M, and K/2 terms add clog2(K/2).
  function automatic int acc_bits(input int d, input int m, input int k);
    return d + 1 + m + $clog2(k / 2);
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                               input int                 width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/am_rect.sv
// am_rect: full-wave rectifier for signed samples.
//   i_x : signed sample, D_BITS wide
//   o_r : |i_x|, D_BITS wide and never negative; the most negative input
//         maps to the largest positive value instead of wrapping.
module am_rect #(
  parameter int D_BITS = 16
) (
  input  logic signed [D_BITS-1:0] i_x,
  output logic        [D_BITS-1:0] o_r
);

  localparam logic [D_BITS-1:0] MOST_NEG = {1'b1, {(D_BITS-1){1'b0}}};
  localparam logic [D_BITS-1:0] MOST_POS = {1'b0, {(D_BITS-1){1'b1}}};

  logic [D_BITS-1:0] w_neg;

  assign w_neg = ~$unsigned(i_x) + D_BITS'(1);

  always_comb begin
    if ($unsigned(i_x) == MOST_NEG) o_r = MOST_POS;
    else if (i_x[D_BITS-1])         o_r = w_neg;
    else                            o_r = $unsigned(i_x);
  end

endmodule

// File: rtl/am_env_demod.sv
// am_env_demod: AM envelope recovery = rectify -> symmetric K-tap FIR -> decimate by R.
// A single multiplier walks the K/2 symmetric tap pairs of a snapshot of the
// delay line, so one output takes K/2 MAC cycles plus one DONE cycle.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   x_i, x_valid_i : signed sample, accepted on every rising edge with x_valid_i high
//   a_i            : K/2 packed signed half-coefficients, a_i[0] is the centre pair
//   y_o, y_valid_o : saturated filter output, registered; y_valid_o pulses one cycle
//   busy_o         : MAC engine is computing (MAC or DONE)
//   ovf_o          : one-cycle pulse after a decimation trigger was dropped
//   dbg_state_o    : current engine state
// Handshake: there is no ready; every x_valid_i-high edge consumes x_i and
// y_valid_o is a single-cycle pulse with no backpressure.
module am_env_demod
  import am_demod_pkg::*;
#(
  parameter int K      = 32,
  parameter int D_BITS = 16,
  parameter int M_BITS = 16,
  parameter int R      = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic signed [D_BITS-1:0]         x_i,
  input  logic                             x_valid_i,
  input  logic        [K/2*M_BITS-1:0]     a_i,
  output logic signed [D_BITS+M_BITS-1:0]  y_o,
  output logic                             y_valid_o,
  output logic                             busy_o,
  output logic                             ovf_o,
  output state_t                           dbg_state_o
);

  localparam int HALF     = K / 2;
  localparam int Y_BITS   = D_BITS + M_BITS;
  localparam int P_BITS   = D_BITS + M_BITS + 1;
  localparam int ACC_BITS = acc_bits(D_BITS, M_BITS, K);
  localparam int IDX_W    = $clog2(K);
  localparam int J_W      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PH_W     = (R > 1) ? $clog2(R) : 1;

  logic [D_BITS-1:0]          r_d [K];
  logic [D_BITS-1:0]          r_s [K];
  logic signed [ACC_BITS-1:0] r_acc;
  logic [J_W-1:0]             r_j;
  logic [PH_W-1:0]            r_ph;
  state_t                     r_state;
  logic signed [Y_BITS-1:0]   r_y;
  logic                       r_y_valid;
  logic                       r_ovf;

  logic [D_BITS-1:0]          w_r;
  logic                       w_trig;
  logic signed [M_BITS-1:0]   w_a [HALF];
  logic [IDX_W-1:0]           w_lo_idx;
  logic [IDX_W-1:0]           w_hi_idx;
  logic [D_BITS:0]            w_pre_u;
  logic signed [P_BITS-1:0]   w_coef_x;
  logic signed [P_BITS-1:0]   w_pre_x;
  logic signed [P_BITS-1:0]   w_prod;
  logic signed [ACC_BITS-1:0] w_prod_x;
  logic signed [63:0]         w_sat;

  am_rect #(.D_BITS(D_BITS)) u_rect (
    .i_x (x_i),
    .o_r (w_r)
  );

  for (genvar g = 0; g < HALF; g++) begin : g_coef
    assign w_a[g] = a_i[g*M_BITS +: M_BITS];
  end

  assign w_trig = x_valid_i && (r_ph == PH_W'(R - 1));

  // Tap pair j sits symmetrically around the centre of the snapshot.
  assign w_lo_idx = IDX_W'(HALF - 1) - IDX_W'(r_j);
  assign w_hi_idx = IDX_W'(HALF) + IDX_W'(r_j);

  // Rectified samples are non-negative, so the zero-extended pre-add is a
  // positive signed value one bit wider than a sample.
  assign w_pre_u  = {1'b0, r_s[w_lo_idx]} + {1'b0, r_s[w_hi_idx]};
  assign w_pre_x  = P_BITS'($signed(w_pre_u));
  assign w_coef_x = P_BITS'(w_a[r_j]);
  assign w_prod   = w_coef_x * w_pre_x;
  assign w_prod_x = ACC_BITS'(w_prod);
  assign w_sat    = sat_s(64'(r_acc), Y_BITS);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < K; i++) begin
        r_d[i] <= '0;
        r_s[i] <= '0;
      end
      r_acc     <= '0;
      r_j       <= '0;
      r_ph      <= '0;
      r_state   <= IDLE;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      r_ovf     <= 1'b0;

      if (x_valid_i) begin
        r_d[0] <= w_r;
        for (int i = 1; i < K; i++) r_d[i] <= r_d[i-1];
        r_ph <= (r_ph == PH_W'(R - 1)) ? '0 : r_ph + PH_W'(1);
      end

      // A trigger arriving while the engine is still busy is lost.
      if (w_trig && (r_state != IDLE)) r_ovf <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_trig) begin
            // Snapshot the line as it will look after this edge's shift.
            r_s[0] <= w_r;
            for (int i = 1; i < K; i++) r_s[i] <= r_d[i-1];
            r_acc   <= '0;
            r_j     <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= r_acc + w_prod_x;
          if (r_j == J_W'(HALF - 1)) r_state <= DONE;
          else                       r_j     <= r_j + J_W'(1);
        end
        DONE: begin
          r_y       <= w_sat[Y_BITS-1:0];
          r_y_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign y_o         = r_y;
  assign y_valid_o   = r_y_valid;
  assign busy_o      = (r_state != IDLE);
  assign ovf_o       = r_ovf;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_am_env_demod.sv
// Bench for am_env_demod. Three instances (R = 8, 1, 2) share the stimulus;
// 'sel' picks which one the monitor watches. The reference model keeps the
// rectified sample history and forms each output as the dot product with the
// full K-tap impulse response, clamped to the 32-bit signed range.
module tb_am_env_demod;
  import am_demod_pkg::*;

  localparam int K    = 32;
  localparam int D    = 16;
  localparam int M    = 16;
  localparam int HALF = K / 2;
  localparam int YW   = D + M;
  localparam int LAT  = HALF + 1;
  localparam int GAP  = HALF + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [D-1:0] x = '0;
  logic x_valid = 1'b0;
  logic [HALF*M-1:0] a_vec = '0;

  logic signed [YW-1:0] y8, y1, y2;
  logic yv8, yv1, yv2, busy8, busy1, busy2, ovf8, ovf1, ovf2;
  state_t st8, st1, st2;

  am_env_demod #(.K(K), .D_BITS(D), .M_BITS(M), .R(8)) u_dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .x_i(x), .x_valid_i(x_valid), .a_i(a_vec),
    .y_o(y8), .y_valid_o(yv8), .busy_o(busy8), .ovf_o(ovf8), .dbg_state_o(st8));
  am_env_demod #(.K(K), .D_BITS(D), .M_BITS(M), .R(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .x_i(x), .x_valid_i(x_valid), .a_i(a_vec),
    .y_o(y1), .y_valid_o(yv1), .busy_o(busy1), .ovf_o(ovf1), .dbg_state_o(st1));
  am_env_demod #(.K(K), .D_BITS(D), .M_BITS(M), .R(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .x_i(x), .x_valid_i(x_valid), .a_i(a_vec),
    .y_o(y2), .y_valid_o(yv2), .busy_o(busy2), .ovf_o(ovf2), .dbg_state_o(st2));

  int sel = 0;
  logic [YW-1:0] y_sel;
  logic yv_sel, busy_sel, ovf_sel;
  always_comb begin
    case (sel)
      1:       begin y_sel = y1; yv_sel = yv1; busy_sel = busy1; ovf_sel = ovf1; end
      2:       begin y_sel = y2; yv_sel = yv2; busy_sel = busy2; ovf_sel = ovf2; end
      default: begin y_sel = y8; yv_sel = yv8; busy_sel = busy8; ovf_sel = ovf8; end
    endcase
  end

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- monitor ----------------
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [YW-1:0] obs_q[$];
  longint obs_cyc_q[$];
  int ovf_seen = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (yv_sel) begin
        obs_q.push_back(y_sel);
        obs_cyc_q.push_back(cyc);
      end
      if (ovf_sel) ovf_seen++;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int coef[HALF];
  int hist[K];
  int ph = 0;
  int cur_r = 8;
  bit have_last = 1'b0;
  longint last_acc = 0;
  logic [YW-1:0] exp_q[$];
  longint exp_cyc_q[$];
  int exp_ovf = 0;

  function automatic int rect(input int v);
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  // Full impulse response h[p]: tap p pairs with tap K-1-p.
  function automatic logic [YW-1:0] model_y();
    longint s = 0;
    int h;
    for (int p = 0; p < K; p++) begin
      h = (p < HALF) ? coef[HALF-1-p] : coef[p-HALF];
      s += longint'(h) * longint'(hist[p]);
    end
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[YW-1:0];
  endfunction

  task automatic model_clear;
    for (int p = 0; p < K; p++) hist[p] = 0;
    ph = 0;
    have_last = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
    exp_ovf = 0;
    ovf_seen = 0;
  endtask

  task automatic load_coefs;
    for (int j = 0; j < HALF; j++) a_vec[j*M +: M] = coef[j][M-1:0];
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input int xv);
    longint e;
    @(negedge clk);
    x = xv[D-1:0];
    x_valid = 1'b1;
    e = cyc + 1;
    for (int p = K - 1; p > 0; p--) hist[p] = hist[p-1];
    hist[0] = rect(xv);
    if (ph == cur_r - 1) begin
      ph = 0;
      if (!have_last || (e - last_acc) >= GAP) begin
        exp_q.push_back(model_y());
        exp_cyc_q.push_back(e + LAT);
        last_acc = e;
        have_last = 1'b1;
      end else begin
        exp_ovf++;
      end
    end else begin
      ph++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      x_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int s, input int r);
    @(negedge clk);
    rst_n = 1'b0;
    x_valid = 1'b0;
    sel = s;
    cur_r = r;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    x_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({y8, yv8, busy8, ovf8} !== '0) begin
      tests_failed++;
      $display("FAIL reset_r8: y=%0d v=%0b busy=%0b ovf=%0b, want all 0", y8, yv8, busy8, ovf8);
    end
    tests_run++;
    if (st8 !== IDLE || st1 !== IDLE || st2 !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d/%0d/%0d, want IDLE", st8, st1, st2);
    end
    tests_run++;
    if ({y1, yv1, busy1, ovf1, y2, yv2, busy2, ovf2} !== '0) begin
      tests_failed++;
      $display("FAIL reset_r1_r2: y1=%0d y2=%0d, want 0 with flags low", y1, y2);
    end
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_dc;
    logic [YW-1:0] ev, ov, last;
    longint ec, oc;
    do_reset(0, 8);
    for (int j = 0; j < HALF; j++) coef[j] = 1;
    load_coefs();
    for (int i = 0; i < 64; i++) begin push(100); idle(2); end
    idle(30);
    tests_run++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      tests_failed++;
      $display("FAIL dc_count: got %0d outputs, want 8", obs_q.size());
    end
    last = '0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      last = ov;
      tests_run++;
      if (ov !== ev || oc != ec) begin
        tests_failed++;
        $display("FAIL dc_out: got %0d @%0d, want %0d @%0d", $signed(ov), oc, $signed(ev), ec);
      end
    end
    tests_run++;
    if (last !== 32'd3200) begin
      tests_failed++;
      $display("FAIL dc_settled: got %0d, want 3200", $signed(last));
    end
  endtask

  task automatic test_rectify;
    logic [YW-1:0] ev, ov, last;
    longint ec, oc;
    int vals[2] = '{-100, -32768};
    logic [YW-1:0] want[2] = '{32'd3200, 32'd1048544};
    for (int t = 0; t < 2; t++) begin
      do_reset(0, 8);
      for (int i = 0; i < 64; i++) begin push(vals[t]); idle(2); end
      idle(30);
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin
        tests_failed++;
        $display("FAIL rect_count: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
      end
      last = '0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        ev = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        ov = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        last = ov;
        tests_run++;
        if (ov !== ev || oc != ec) begin
          tests_failed++;
          $display("FAIL rect_out: got %0d @%0d, want %0d @%0d", $signed(ov), oc, $signed(ev), ec);
        end
      end
      tests_run++;
      if (last !== want[t]) begin
        tests_failed++;
        $display("FAIL rect_settled x=%0d: got %0d, want %0d", vals[t], $signed(last), want[t]);
      end
    end
  endtask

  task automatic test_impulse;
    logic [YW-1:0] ev, ov;
    longint ec, oc;
    logic [YW-1:0] got[34];
    int n = 0;
    int tbl[HALF] = '{87, 84, 78, 70, 61, 51, 40, 31, 22, 15, 10, 6, 3, 1, 1, 0};
    do_reset(1, 1);
    for (int j = 0; j < HALF; j++) coef[j] = tbl[j];
    load_coefs();
    for (int i = 0; i < 34; i++) got[i] = '1;
    for (int i = 0; i < 34; i++) begin push((i == 0) ? 1000 : 0); idle(19); end
    idle(10);
    tests_run++;
    if (obs_q.size() != 34) begin
      tests_failed++;
      $display("FAIL imp_count: got %0d outputs, want 34", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      if (n < 34) got[n] = ov;
      n++;
      tests_run++;
      if (ov !== ev || oc != ec) begin
        tests_failed++;
        $display("FAIL imp_out[%0d]: got %0d @%0d, want %0d @%0d", n - 1, $signed(ov), oc, $signed(ev), ec);
      end
    end
    tests_run++;
    if (got[0] !== 32'd0 || got[1] !== 32'd1000 || got[3] !== 32'd3000 || got[4] !== 32'd6000) begin
      tests_failed++;
      $display("FAIL imp_head: got %0d %0d %0d %0d, want 0 1000 3000 6000", got[0], got[1], got[3], got[4]);
    end
    tests_run++;
    if (got[15] !== 32'd87000 || got[16] !== 32'd87000 || got[31] !== 32'd0) begin
      tests_failed++;
      $display("FAIL imp_peak: got %0d %0d tail %0d, want 87000 87000 tail 0", got[15], got[16], got[31]);
    end
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (got[k] !== got[31-k]) begin
        tests_failed++;
        $display("FAIL imp_sym[%0d]: got %0d vs %0d, want equal", k, got[k], got[31-k]);
      end
    end
  endtask

  task automatic test_saturation;
    logic [YW-1:0] ev, ov, last;
    longint ec, oc;
    int cv[2] = '{32767, -32768};
    logic [YW-1:0] want[2] = '{32'h7fffffff, 32'h80000000};
    for (int t = 0; t < 2; t++) begin
      do_reset(0, 8);
      for (int j = 0; j < HALF; j++) coef[j] = cv[t];
      load_coefs();
      for (int i = 0; i < 64; i++) begin push(32767); idle(2); end
      idle(30);
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin
        tests_failed++;
        $display("FAIL sat_count: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
      end
      last = '0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        ev = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        ov = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        last = ov;
        tests_run++;
        if (ov !== ev || oc != ec) begin
          tests_failed++;
          $display("FAIL sat_out: got %0d @%0d, want %0d @%0d", $signed(ov), oc, $signed(ev), ec);
        end
      end
      tests_run++;
      if (last !== want[t]) begin
        tests_failed++;
        $display("FAIL sat_settled coef=%0d: got %h, want %h", cv[t], last, want[t]);
      end
    end
  endtask

  task automatic test_overrun;
    logic [YW-1:0] ev, ov;
    longint ec, oc;
    logic signed [D-1:0] tmp;
    do_reset(2, 2);
    for (int j = 0; j < HALF; j++) coef[j] = $urandom_range(0, 200) - 100;
    load_coefs();
    for (int i = 0; i < 40; i++) begin
      tmp = D'($urandom_range(0, 65535));
      push(int'(tmp));
    end
    idle(30);
    tests_run++;
    if (obs_q.size() != 3) begin
      tests_failed++;
      $display("FAIL ovr_count: got %0d outputs, want 3", obs_q.size());
    end
    tests_run++;
    if (ovf_seen != 17) begin
      tests_failed++;
      $display("FAIL ovr_ovf: got %0d pulses, want 17", ovf_seen);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      tests_run++;
      if (ov !== ev || oc != ec) begin
        tests_failed++;
        $display("FAIL ovr_out: got %0d @%0d, want %0d @%0d", $signed(ov), oc, $signed(ev), ec);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [YW-1:0] ev, ov;
    longint ec, oc;
    do_reset(1, 1);
    for (int j = 0; j < HALF; j++) coef[j] = 1;
    load_coefs();
    push(1000); idle(17);   // next trigger 18 edges later: accepted
    push(1000); idle(16);   // next trigger 17 edges later: dropped
    push(1000); idle(30);
    tests_run++;
    if (obs_q.size() != 2 || ovf_seen != 1) begin
      tests_failed++;
      $display("FAIL b2b_counts: got %0d outputs %0d ovf, want 2 outputs 1 ovf", obs_q.size(), ovf_seen);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      tests_run++;
      if (ov !== ev || oc != ec) begin
        tests_failed++;
        $display("FAIL b2b_out: got %0d @%0d, want %0d @%0d", $signed(ov), oc, $signed(ev), ec);
      end
    end
  endtask

  task automatic test_reset_mid_mac;
    logic [YW-1:0] ev, ov;
    longint ec, oc;
    do_reset(0, 8);
    for (int j = 0; j < HALF; j++) coef[j] = 1;
    load_coefs();
    for (int i = 0; i < 8; i++) push(500);
    idle(25);
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'd4000) begin
      tests_failed++;
      $display("FAIL mid_first: got %0d outputs, want one of 4000", obs_q.size());
    end
    obs_q.delete(); obs_cyc_q.delete(); exp_q.delete(); exp_cyc_q.delete();
    for (int i = 0; i < 8; i++) push(500);
    idle(6);
    tests_run++;
    if (busy_sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_busy: got busy=%0b, want 1", busy_sel);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (y_sel !== '0 || yv_sel !== 1'b0 || busy_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_abort: got y=%0d v=%0b busy=%0b, want 0 0 0", $signed(y_sel), yv_sel, busy_sel);
    end
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    for (int i = 0; i < 7; i++) push(300);
    idle(25);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL mid_no_output: got %0d outputs, want 0", obs_q.size());
    end
    push(300);
    idle(25);
    tests_run++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL mid_fresh_count: got %0d outputs, want 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      tests_run++;
      if (ov !== ev || oc != ec || ov !== 32'd2400) begin
        tests_failed++;
        $display("FAIL mid_fresh: got %0d @%0d, want 2400 (%0d) @%0d", $signed(ov), oc, $signed(ev), ec);
      end
    end
  endtask

  task automatic test_random;
    logic [YW-1:0] ev, ov;
    longint ec, oc;
    logic signed [M-1:0] tc;
    logic signed [D-1:0] tmp;
    do_reset(0, 8);
    for (int j = 0; j < HALF; j++) begin
      tc = M'($urandom_range(0, 65535));
      coef[j] = int'(tc);
    end
    load_coefs();
    for (int i = 0; i < 300; i++) begin
      tmp = ($urandom_range(0, 15) == 0) ? -16'sd32768 : D'($urandom_range(0, 65535));
      push(int'(tmp));
      idle($urandom_range(0, 2));
    end
    idle(30);
    tests_run++;
    if (obs_q.size() != exp_q.size() || ovf_seen != exp_ovf) begin
      tests_failed++;
      $display("FAIL rnd_counts: got %0d outputs %0d ovf, want %0d outputs %0d ovf",
               obs_q.size(), ovf_seen, exp_q.size(), exp_ovf);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ev = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      ov = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      tests_run++;
      if (ov !== ev || oc != ec) begin
        tests_failed++;
        $display("FAIL rnd_out: got %0d @%0d, want %0d @%0d", $signed(ov), oc, $signed(ev), ec);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dc();
    test_rectify();
    test_impulse();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid_mac();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/am_env_demod.md
Name: am_env_demod

Overview:
- Receive-side counterpart of the AM stimulus path. It recovers the modulating envelope from a sampled AM signal.
- Datapath: full-wave rectification, symmetric K-tap low-pass FIR, decimation by R.
- Uses one time-multiplexed multiplier instead of K parallel multipliers.
- Sits after the sample source and before any audio/envelope consumer.

Parameters:
- K, 32: number of taps; even; coefficients are symmetric.
- D_BITS, 16: input sample width, signed.
- M_BITS, 16: coefficient width, signed.
- R, 8: decimation ratio, R >= 1. One output is produced per R accepted samples.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- x_i  in  D_BITS  signed input sample
- x_valid_i  in  1  x_i accepted on any rising edge where this is high
- a_i  in  K/2 x M_BITS  packed signed half-coefficient set; must be held static during operation
- y_o  out  D_BITS+M_BITS  signed envelope output, registered
- y_valid_o  out  1  one-cycle pulse; y_o is new when high
- busy_o  out  1  high while the MAC engine is computing
- ovf_o  out  1  one-cycle pulse when a trigger is dropped

Behaviour:
- Interface: one clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: all outputs 0; delay line, snapshot, accumulator and phase counter 0; state IDLE.
- Rectify:
  - r = |x_i|.
  - x_i = -2^(D_BITS-1) saturates to 2^(D_BITS-1)-1.
  - r is non-negative, D_BITS wide.
- Delay line d[0..K-1]: on each accepted sample, d[0] <= r and d[i] <= d[i-1]. d[0] is always the newest sample.
- Phase counter ph, 0..R-1:
  - Increments on each accepted sample and wraps at R-1 to 0.
  - A trigger occurs when a sample is accepted with ph == R-1.
- Trigger while state IDLE: on the same edge, snapshot s[] <= the post-shift delay line contents (including the new sample). Acc <= 0, j <= 0, state goes to MAC.
- Trigger while state is not IDLE:
  - The trigger is dropped and ovf_o pulses on the next cycle.
  - The sample is still shifted into the delay line and ph still wraps.
- State MAC, K/2 cycles, j = 0..K/2-1:
  - acc += a_i[j] * (s[K/2-1-j] + s[K/2+j]).
  - The pre-add is D_BITS+1 bits, zero-extended and kept signed.
  - a_i[0] is the centre tap pair; a_i[K/2-1] is the outermost pair.
  - After j = K/2-1, go to state DONE.
- State DONE, 1 cycle:
  - y_o <= sat(acc): saturate to the signed D_BITS+M_BITS range.
  - y_valid_o = 1 on this cycle. Return to IDLE.
- Accumulator width: ACC_BITS = D_BITS+1+M_BITS+clog2(K/2). Overflow inside the accumulator is impossible.
- busy_o = 1 in states MAC and DONE.
- Latency: y_valid_o is high in the cycle starting K/2+1 edges after the trigger edge.
- Throughput: no overrun if triggers are spaced by at least K/2+2 cycles.
- y_o holds its value between pulses.
- Reset mid-operation: everything clears immediately and no y_valid_o is produced for the aborted computation.
- x_valid_i low: nothing shifts; ph and the pipeline are otherwise unaffected.

Decomposition:
- Package am_demod_pkg holds:
  - typedef enum state_t {IDLE, MAC, DONE};
  - localparam function acc_bits(D, M, K);
  - saturation function sat_s(value, width).
- One sub-module, am_rect: rectify + saturate, D_BITS in / D_BITS out. It is reused by any future envelope path.
- Everything else (MAC, FSM, delay line) stays in am_env_demod.

Test Plan:
- Constant DC, R=8:
  - Stimulus: all a_i = 1; x = 100 on every cycle for 64 samples.
  - Required: after the line fills, every y_valid_o shows y_o = 3200, one pulse per 8 samples. Latency is exactly K/2+1 = 17 cycles after the trigger edge.
- Rectification:
  - x = -100 constant, same coefficients → y_o = 3200.
  - x = -32768 constant → y_o = 32 * 32767 = 1048544.
- Impulse, R=1, samples spaced 20 cycles:
  - Stimulus: a_i = {87,84,78,70,61,51,40,31,22,15,10,6,3,1,1,0} with a_i[0] = 87; x = 1000 once, then zeros.
  - Required: successive outputs are 0, 1000, 1000, 3000, 6000, …, 87000, 87000, …, 0. The sequence is symmetric, 32 nonzero-window outputs.
- Saturation: all a_i = 32767, x = 32767 constant → y_o = 2147483647 (not wrapped).
- Overrun:
  - Stimulus: R=2, x_valid_i held high continuously.
  - Required: the first trigger computes; triggers during busy_o produce ovf_o pulses and no extra y_valid_o. The computed result matches the snapshot taken at the accepted trigger.
- Reset mid-MAC: assert rst_n_i low 5 cycles into MAC → y_o = 0, y_valid_o = 0, busy_o = 0 immediately. The first output after release needs a fresh R samples.
